// File: rtl/pr_free_list_pkg.sv
// Shared types and default sizing for the physical-register free list.
package pr_free_list_pkg;

    localparam int FL_NUM_PR   = 64;
    localparam int FL_NUM_ARCH = 32;
    localparam int FL_NUM_FREE = 2;
    localparam int FL_NUM_CKPT = 4;

    localparam int FL_DEPTH = FL_NUM_PR - FL_NUM_ARCH;
    localparam int FL_PTR_W = $clog2(FL_DEPTH) + 1;

    typedef logic [$clog2(FL_NUM_PR)-1:0]   pr_tag_t;
    typedef logic [FL_PTR_W-1:0]            fl_ptr_t;
    typedef logic [$clog2(FL_NUM_CKPT)-1:0] ckpt_id_t;

endpackage

// File: rtl/pr_free_list_ckpt_table.sv
// Checkpoint table of free-list head pointers: one write port, one asynchronous read port.
module pr_ckpt_table
    import pr_free_list_pkg::*;
#(
    parameter int PTR_W    = FL_PTR_W,
    parameter int NUM_CKPT = FL_NUM_CKPT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we_i,
    input  logic [$clog2(NUM_CKPT)-1:0] wid_i,
    input  logic [PTR_W-1:0]            wdata_i,
    input  logic [$clog2(NUM_CKPT)-1:0] rid_i,
    output logic [PTR_W-1:0]            rdata_o
);

    logic [PTR_W-1:0] slot_q [NUM_CKPT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                slot_q[i] <= '0;
            end
        end else if (we_i) begin
            slot_q[wid_i] <= wdata_i;
        end
    end

    assign rdata_o = slot_q[rid_i];

endmodule

// File: rtl/pr_free_list.sv
// Physical-register free list: 2-wide all-or-nothing allocation, multi-port release, one-cycle recall.
// Optional macro FREELIST_STATS_EN adds the saturating alloc_stall_cnt_o counter.
module pr_free_list
    import pr_free_list_pkg::*;
#(
    parameter int NUM_PR   = FL_NUM_PR,
    parameter int NUM_ARCH = FL_NUM_ARCH,
    parameter int NUM_FREE = FL_NUM_FREE,
    parameter int NUM_CKPT = FL_NUM_CKPT
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [1:0]                          alloc_req_i,
    input  logic                                ext_stall_i,
    output logic [$clog2(NUM_PR)-1:0]           alloc_addr_o [2],
    output logic                                alloc_ok_o,
    input  logic [NUM_FREE-1:0]                 free_en_i,
    input  logic [$clog2(NUM_PR)-1:0]           free_addr_i [NUM_FREE],
    input  logic                                ckpt_take_i,
    input  logic [$clog2(NUM_CKPT)-1:0]         ckpt_id_i,
    input  logic                                if_recall_i,
    input  logic [$clog2(NUM_CKPT)-1:0]         recall_id_i,
    output logic [$clog2(NUM_PR-NUM_ARCH):0]    free_count_o
`ifdef FREELIST_STATS_EN
    ,
    output logic [31:0]                         alloc_stall_cnt_o
`endif
);

    localparam int D     = NUM_PR - NUM_ARCH;
    localparam int IDX_W = $clog2(D);
    localparam int PTR_W = IDX_W + 1;
    localparam int TAG_W = $clog2(NUM_PR);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] ckpt_rd;
    logic [PTR_W-1:0] fcnt;
    logic [PTR_W-1:0] req_cnt;
    logic [PTR_W-1:0] free_cnt;
    logic [IDX_W-1:0] lane1_idx;
    logic [IDX_W-1:0] wr_idx [NUM_FREE];
    logic [TAG_W-1:0] mem_q [D];
    logic [NUM_CKPT-1:0] ckpt_vld_q, ckpt_vld_d;
    logic             grant;
    logic             ckpt_we;

    // Lane 1 reads one slot further only when lane 0 also consumes a tag.
    always_comb begin
        req_cnt    = PTR_W'(alloc_req_i[0]) + PTR_W'(alloc_req_i[1]);
        fcnt       = tail_q - head_q;
        grant      = (|alloc_req_i) && !ext_stall_i && !if_recall_i && (fcnt >= req_cnt);
        lane1_idx  = head_q[IDX_W-1:0] + {{(IDX_W-1){1'b0}}, alloc_req_i[0]};
        alloc_addr_o[0] = mem_q[head_q[IDX_W-1:0]];
        alloc_addr_o[1] = mem_q[lane1_idx];
        alloc_ok_o   = grant;
        free_count_o = fcnt;
    end

    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < NUM_FREE; i++) begin
            wr_idx[i] = tail_q[IDX_W-1:0] + free_cnt[IDX_W-1:0];
            free_cnt  = free_cnt + PTR_W'(free_en_i[i]);
        end
        tail_d = tail_q + free_cnt;
    end

    // Recall wins over allocation and suppresses the checkpoint write.
    always_comb begin
        head_d     = head_q;
        ckpt_we    = ckpt_take_i && !if_recall_i;
        ckpt_vld_d = ckpt_vld_q;
        if (if_recall_i) begin
            head_d = ckpt_rd;
        end else if (grant) begin
            head_d = head_q + req_cnt;
        end
        if (ckpt_we) begin
            ckpt_vld_d[ckpt_id_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= PTR_W'(D);
            ckpt_vld_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            ckpt_vld_q <= ckpt_vld_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < D; i++) begin
                mem_q[i] <= TAG_W'(NUM_ARCH + i);
            end
        end else begin
            for (int i = 0; i < NUM_FREE; i++) begin
                if (free_en_i[i]) begin
                    mem_q[wr_idx[i]] <= free_addr_i[i];
                end
            end
        end
    end

    pr_ckpt_table #(
        .PTR_W    (PTR_W),
        .NUM_CKPT (NUM_CKPT)
    ) u_ckpt (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ckpt_we),
        .wid_i   (ckpt_id_i),
        .wdata_i (head_d),
        .rid_i   (recall_id_i),
        .rdata_o (ckpt_rd)
    );

`ifdef FREELIST_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((|alloc_req_i) && !ext_stall_i && !if_recall_i && !grant && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign alloc_stall_cnt_o = stall_cnt_q;
`endif

    a_free_overflow: assert property (@(posedge clk) disable iff (rst)
        free_cnt <= (PTR_W'(D) - fcnt));

    a_recall_valid: assert property (@(posedge clk) disable iff (rst)
        if_recall_i |-> ckpt_vld_q[recall_id_i]);

endmodule

// File: tb/tb_pr_free_list.sv
// Self-checking bench for pr_free_list: vector table driven through an expected-value queue.
module tb_pr_free_list;
    import pr_free_list_pkg::*;

    logic     clk = 1'b0;
    logic     rst;
    logic [1:0] alloc_req;
    logic     ext_stall;
    pr_tag_t  alloc_addr [2];
    logic     alloc_ok;
    logic [1:0] free_en;
    pr_tag_t  free_addr [2];
    logic     ckpt_take;
    ckpt_id_t ckpt_id;
    logic     if_recall;
    ckpt_id_t recall_id;
    fl_ptr_t  free_count;
`ifdef FREELIST_STATS_EN
    logic [31:0] alloc_stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pr_free_list dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_req_i  (alloc_req),
        .ext_stall_i  (ext_stall),
        .alloc_addr_o (alloc_addr),
        .alloc_ok_o   (alloc_ok),
        .free_en_i    (free_en),
        .free_addr_i  (free_addr),
        .ckpt_take_i  (ckpt_take),
        .ckpt_id_i    (ckpt_id),
        .if_recall_i  (if_recall),
        .recall_id_i  (recall_id),
        .free_count_o (free_count)
`ifdef FREELIST_STATS_EN
        ,
        .alloc_stall_cnt_o (alloc_stall_cnt)
`endif
    );

    typedef struct {
        logic [1:0] req;
        logic       stall;
        logic [1:0] fen;
        int         fa0;
        int         fa1;
        logic       take;
        int         tid;
        logic       rec;
        int         rid;
        logic       ok;
        int         fc;
        int         a0;
        int         a1;
        logic [1:0] chk;
    } vec_t;

    typedef struct {
        logic       ok;
        int         fc;
        int         a0;
        int         a1;
        logic [1:0] chk;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[24];

    function automatic vec_t mk(logic [1:0] req, logic stall, logic [1:0] fen, int fa0, int fa1,
                                logic take, int tid, logic rec, int rid,
                                logic ok, int fc, int a0, int a1, logic [1:0] chk);
        vec_t v;
        v.req = req; v.stall = stall; v.fen = fen; v.fa0 = fa0; v.fa1 = fa1;
        v.take = take; v.tid = tid; v.rec = rec; v.rid = rid;
        v.ok = ok; v.fc = fc; v.a0 = a0; v.a1 = a1; v.chk = chk;
        return v;
    endfunction

    task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %0d, expected %0d", nm, id, act, exp);
        end
    endtask

    task automatic set_idle();
        alloc_req = 2'b00; ext_stall = 1'b0; free_en = 2'b00;
        free_addr[0] = '0; free_addr[1] = '0;
        ckpt_take = 1'b0; ckpt_id = '0; if_recall = 1'b0; recall_id = '0;
    endtask

    task automatic apply(input vec_t v, input int id);
        exp_t e;
        exp_t got;
        alloc_req    = v.req;
        ext_stall    = v.stall;
        free_en      = v.fen;
        free_addr[0] = pr_tag_t'(v.fa0);
        free_addr[1] = pr_tag_t'(v.fa1);
        ckpt_take    = v.take;
        ckpt_id      = ckpt_id_t'(v.tid);
        if_recall    = v.rec;
        recall_id    = ckpt_id_t'(v.rid);
        e.ok = v.ok; e.fc = v.fc; e.a0 = v.a0; e.a1 = v.a1; e.chk = v.chk;
        sbq.push_back(e);
        @(negedge clk);
        got = sbq.pop_front();
        check("alloc_ok", id, 32'(alloc_ok), 32'(got.ok));
        check("free_count", id, 32'(free_count), got.fc);
        if (got.chk[0]) check("lane0_tag", id, 32'(alloc_addr[0]), got.a0);
        if (got.chk[1]) check("lane1_tag", id, 32'(alloc_addr[1]), got.a1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
        $fatal(1);
    end

    initial begin
        // Starts with head=32 tail=32 (list drained by the 16 double grants).
        //            req   st fen   fa0 fa1 tk id rc id  ok fc  a0 a1 chk
        tbl[0]  = mk(2'b11, 0, 2'b00,  0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00);
        tbl[1]  = mk(2'b00, 0, 2'b01, 50,  0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00);
        tbl[2]  = mk(2'b11, 0, 2'b01, 40,  0, 0, 0, 0, 0, 0, 1,  0, 0, 2'b00);
        tbl[3]  = mk(2'b11, 0, 2'b00,  0,  0, 0, 0, 0, 0, 1, 2, 50, 40, 2'b11);
        tbl[4]  = mk(2'b00, 0, 2'b11, 32, 33, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00);
        tbl[5]  = mk(2'b10, 0, 2'b00,  0,  0, 0, 0, 0, 0, 1, 2,  0, 32, 2'b10);
        tbl[6]  = mk(2'b01, 0, 2'b00,  0,  0, 0, 0, 0, 0, 1, 1, 33, 0, 2'b01);
        tbl[7]  = mk(2'b00, 0, 2'b11,  0,  1, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00);
        tbl[8]  = mk(2'b00, 0, 2'b11,  2,  3, 0, 0, 0, 0, 0, 2,  0, 0, 2'b00);
        tbl[9]  = mk(2'b00, 0, 2'b11,  4,  5, 0, 0, 0, 0, 0, 4,  0, 0, 2'b00);
        tbl[10] = mk(2'b00, 0, 2'b11,  6,  7, 0, 0, 0, 0, 0, 6,  0, 0, 2'b00);
        tbl[11] = mk(2'b00, 0, 2'b11,  8,  9, 1, 2, 0, 0, 0, 8,  0, 0, 2'b00);
        tbl[12] = mk(2'b11, 0, 2'b00,  0,  0, 1, 1, 0, 0, 1, 10, 0, 1, 2'b11);
        tbl[13] = mk(2'b11, 0, 2'b00,  0,  0, 0, 0, 0, 0, 1, 8,  2, 3, 2'b11);
        tbl[14] = mk(2'b11, 0, 2'b00,  0,  0, 0, 0, 0, 0, 1, 6,  4, 5, 2'b11);
        tbl[15] = mk(2'b11, 0, 2'b00,  0,  0, 0, 0, 0, 0, 1, 4,  6, 7, 2'b11);
        tbl[16] = mk(2'b00, 0, 2'b00,  0,  0, 0, 0, 1, 1, 0, 2,  0, 0, 2'b00);
        tbl[17] = mk(2'b11, 0, 2'b11, 20, 21, 1, 2, 1, 1, 0, 8,  2, 0, 2'b01);
        tbl[18] = mk(2'b00, 0, 2'b00,  0,  0, 0, 0, 0, 0, 0, 10, 2, 0, 2'b01);
        tbl[19] = mk(2'b00, 0, 2'b00,  0,  0, 0, 0, 1, 2, 0, 10, 0, 0, 2'b00);
        tbl[20] = mk(2'b11, 0, 2'b00,  0,  0, 0, 0, 0, 0, 1, 12, 0, 1, 2'b11);
        tbl[21] = mk(2'b11, 1, 2'b00,  0,  0, 0, 0, 0, 0, 0, 10, 2, 0, 2'b01);
        tbl[22] = mk(2'b01, 0, 2'b00,  0,  0, 0, 0, 0, 0, 1, 10, 2, 0, 2'b01);
        tbl[23] = mk(2'b10, 0, 2'b00,  0,  0, 0, 0, 0, 0, 1, 9,  0, 3, 2'b10);

        rst = 1'b1;
        set_idle();
        @(posedge clk);
        #1;
        apply(mk(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32, 32, 0, 2'b01), 0);
        rst = 1'b0;

        for (int k = 0; k < 16; k++) begin
            apply(mk(2'b11, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 32 - 2 * k, 32 + 2 * k, 33 + 2 * k, 2'b11), 100 + k);
        end

        for (int i = 0; i < 24; i++) begin
            apply(tbl[i], 200 + i);
        end

        // Reset asserted between clock edges must clear the list immediately.
        set_idle();
        rst = 1'b1;
        #2;
        check("async_reset_free_count", 300, 32'(free_count), 32);
        check("async_reset_lane0", 301, 32'(alloc_addr[0]), 32);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        apply(mk(2'b01, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 32, 32, 0, 2'b01), 302);

`ifdef FREELIST_STATS_EN
        for (int k = 1; k < 16; k++) begin
            apply(mk(2'b11, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 31 - 2 * (k - 1), 33 + 2 * (k - 1), 34 + 2 * (k - 1), 2'b11), 400 + k);
        end
        apply(mk(2'b01, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 63, 0, 2'b01), 416);
        for (int k = 0; k < 5; k++) begin
            apply(mk(2'b11, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00), 420 + k);
        end
        for (int k = 0; k < 2; k++) begin
            apply(mk(2'b11, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00), 430 + k);
        end
        set_idle();
        check("stall_cnt_after_denials", 440, alloc_stall_cnt, 5);
        rst = 1'b1;
        #2;
        check("stall_cnt_async_reset", 441, alloc_stall_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
